// File: rtl/rca_config.sv
// Shared configuration for the RCA load-store queue: sizes and the queued entry layout.
package rca_config;

  localparam int unsigned GRID_NUM_ROWS = 4;
  localparam int unsigned LSQ_DEPTH     = 8;

  typedef logic [$clog2(GRID_NUM_ROWS)-1:0] lsq_row_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  fn3;
    logic        is_load;
    lsq_row_t    row;
  } rca_lsq_entry_t;

endpackage

// File: rtl/rca_lsq_mwfifo.sv
// Multi-write, single-read circular queue: up to NumRows entries written per cycle in row order.
module rca_lsq_mwfifo
  import rca_config::*;
#(
  parameter int unsigned Depth   = LSQ_DEPTH,
  parameter int unsigned NumRows = GRID_NUM_ROWS,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CntW   = PtrW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic           [NumRows-1:0] wr_en_i,
  input  rca_lsq_entry_t [NumRows-1:0] wr_entry_i,
  input  logic                         pop_i,
  output rca_lsq_entry_t               head_o,
  output logic                         head_valid_o,
  output logic [CntW-1:0]              free_o
);

  rca_lsq_entry_t [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, slot;
  logic [CntW-1:0] count_q, count_d, n_enq;

  // Each enabled row takes the next free slot, so slot = tail + number of lower enabled rows.
  always_comb begin
    mem_d = mem_q;
    slot  = tail_q;
    n_enq = '0;
    for (int r = 0; r < NumRows; r++) begin
      if (wr_en_i[r]) begin
        mem_d[slot] = wr_entry_i[r];
        slot        = slot + 1'b1;
        n_enq       = n_enq + 1'b1;
      end
    end
    tail_d  = slot;
    head_d  = head_q + PtrW'(pop_i);
    count_d = count_q + n_enq - CntW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o       = mem_q[head_q];
  assign head_valid_o = (count_q != '0);
  assign free_o       = CntW'(Depth) - count_q;

endmodule

// File: rtl/rca_lsq.sv
// Load-store queue between RCA grid rows and the LSU; loads are serialized and routed back by row.
// Optional statistics counters are built when RCA_LSQ_STATS_EN is defined.
module rca_lsq #(
  parameter int unsigned LSQ_DEPTH     = rca_config::LSQ_DEPTH,
  parameter int unsigned GRID_NUM_ROWS = rca_config::GRID_NUM_ROWS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [GRID_NUM_ROWS-1:0][31:0]  grid_addr_i,
  input  logic [GRID_NUM_ROWS-1:0][31:0]  grid_data_i,
  input  logic [GRID_NUM_ROWS-1:0][2:0]   grid_fn3_i,
  input  logic [GRID_NUM_ROWS-1:0]        grid_load_i,
  input  logic [GRID_NUM_ROWS-1:0]        grid_store_i,
  input  logic [GRID_NUM_ROWS-1:0]        grid_new_request_i,
  output logic                            grid_fifo_full_o,
  output logic [GRID_NUM_ROWS-1:0]        grid_load_complete_o,
  output logic [31:0]                     grid_load_data_o,
  output logic [31:0]                     lsu_rs1_o,
  output logic [31:0]                     lsu_rs2_o,
  output logic [2:0]                      lsu_fn3_o,
  output logic                            lsu_load_o,
  output logic                            lsu_store_o,
  output logic                            lsu_new_request_o,
  output logic                            lsu_rca_lsu_lock_o,
  input  logic                            lsu_ready_i,
  input  logic                            lsu_load_complete_i,
  input  logic [31:0]                     lsu_load_data_i
`ifdef RCA_LSQ_STATS_EN
  ,
  output logic [31:0]                     lsq_loads,
  output logic [31:0]                     lsq_stores,
  output logic [31:0]                     lsq_full_cycles
`endif
);
  import rca_config::*;

  localparam int unsigned CntW = $clog2(LSQ_DEPTH) + 1;

  logic [GRID_NUM_ROWS-1:0]                 wr_en;
  rca_lsq_entry_t [GRID_NUM_ROWS-1:0]       entries;
  rca_lsq_entry_t                           head;
  logic                                     head_valid, issue;
  logic [CntW-1:0]                          free;

  logic        load_pending_q, load_pending_d;
  lsq_row_t    pending_row_q, pending_row_d;
  logic        ret_pulse_q, ret_pulse_d;
  logic [31:0] load_data_q, load_data_d;

  assign grid_fifo_full_o = (free < CntW'(GRID_NUM_ROWS));

  // Rows with an ambiguous load/store encoding, or raised while full, are dropped.
  always_comb begin
    wr_en   = '0;
    entries = '0;
    for (int r = 0; r < GRID_NUM_ROWS; r++) begin
      wr_en[r]   = grid_new_request_i[r] & (grid_load_i[r] ^ grid_store_i[r]) & ~grid_fifo_full_o;
      entries[r] = '{addr: grid_addr_i[r], data: grid_data_i[r], fn3: grid_fn3_i[r],
                     is_load: grid_load_i[r], row: lsq_row_t'(r)};
    end
  end

  rca_lsq_mwfifo #(
    .Depth   (LSQ_DEPTH),
    .NumRows (GRID_NUM_ROWS)
  ) u_mwfifo (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en),
    .wr_entry_i   (entries),
    .pop_i        (issue),
    .head_o       (head),
    .head_valid_o (head_valid),
    .free_o       (free)
  );

  assign issue              = head_valid & lsu_ready_i & ~load_pending_q;
  assign lsu_new_request_o  = issue;
  assign lsu_rs1_o          = head.addr;
  assign lsu_rs2_o          = head.data;
  assign lsu_fn3_o          = head.fn3;
  assign lsu_load_o         = head_valid & head.is_load;
  assign lsu_store_o        = head_valid & ~head.is_load;
  assign lsu_rca_lsu_lock_o = head_valid | load_pending_q | ret_pulse_q;

  // Issue and capture are mutually exclusive: issue needs load_pending clear, capture needs it set.
  always_comb begin
    load_pending_d = load_pending_q;
    pending_row_d  = pending_row_q;
    ret_pulse_d    = 1'b0;
    load_data_d    = load_data_q;
    if (issue && head.is_load) begin
      load_pending_d = 1'b1;
      pending_row_d  = head.row;
    end
    if (lsu_load_complete_i && load_pending_q) begin
      load_pending_d = 1'b0;
      ret_pulse_d    = 1'b1;
      load_data_d    = lsu_load_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_pending_q <= 1'b0;
      pending_row_q  <= '0;
      ret_pulse_q    <= 1'b0;
      load_data_q    <= '0;
    end else begin
      load_pending_q <= load_pending_d;
      pending_row_q  <= pending_row_d;
      ret_pulse_q    <= ret_pulse_d;
      load_data_q    <= load_data_d;
    end
  end

  // pending_row_q still names the returning row here even if a new load issues this cycle.
  assign grid_load_complete_o = ret_pulse_q ? (GRID_NUM_ROWS'(1) << pending_row_q) : '0;
  assign grid_load_data_o     = load_data_q;

`ifdef RCA_LSQ_STATS_EN
  logic [31:0] loads_q, loads_d, stores_q, stores_d, full_q, full_d;

  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    full_d   = full_q;
    if (issue && head.is_load && loads_q != '1)   loads_d  = loads_q + 1'b1;
    if (issue && !head.is_load && stores_q != '1) stores_d = stores_q + 1'b1;
    if (grid_fifo_full_o && full_q != '1)         full_d   = full_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      full_q   <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      full_q   <= full_d;
    end
  end

  assign lsq_loads       = loads_q;
  assign lsq_stores      = stores_q;
  assign lsq_full_cycles = full_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(grid_fifo_full_o && |grid_new_request_i))
        else $warning("rca_lsq: grid request dropped while queue full");
      assert (!(lsu_load_complete_i && !load_pending_q))
        else $warning("rca_lsq: lsu load_complete with no load pending");
    end
  end
`endif

endmodule

// File: tb/tb_rca_lsq.sv
// Scoreboard bench for rca_lsq: expected LSU issues and grid returns are queued at stimulus time.
module tb_rca_lsq;

  localparam int Rows = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [Rows-1:0][31:0] grid_addr, grid_data;
  logic [Rows-1:0][2:0]  grid_fn3;
  logic [Rows-1:0]       grid_load, grid_store, grid_new_request;
  logic                  grid_fifo_full;
  logic [Rows-1:0]       grid_load_complete;
  logic [31:0]           grid_load_data, lsu_rs1, lsu_rs2, lsu_load_data;
  logic [2:0]            lsu_fn3;
  logic                  lsu_load, lsu_store, lsu_new_request, lsu_lock;
  logic                  lsu_ready, lsu_load_complete;
`ifdef RCA_LSQ_STATS_EN
  logic [31:0]           lsq_loads, lsq_stores, lsq_full_cycles;
`endif

  rca_lsq dut (
    .clk                  (clk),
    .rst                  (rst),
    .grid_addr_i          (grid_addr),
    .grid_data_i          (grid_data),
    .grid_fn3_i           (grid_fn3),
    .grid_load_i          (grid_load),
    .grid_store_i         (grid_store),
    .grid_new_request_i   (grid_new_request),
    .grid_fifo_full_o     (grid_fifo_full),
    .grid_load_complete_o (grid_load_complete),
    .grid_load_data_o     (grid_load_data),
    .lsu_rs1_o            (lsu_rs1),
    .lsu_rs2_o            (lsu_rs2),
    .lsu_fn3_o            (lsu_fn3),
    .lsu_load_o           (lsu_load),
    .lsu_store_o          (lsu_store),
    .lsu_new_request_o    (lsu_new_request),
    .lsu_rca_lsu_lock_o   (lsu_lock),
    .lsu_ready_i          (lsu_ready),
    .lsu_load_complete_i  (lsu_load_complete),
    .lsu_load_data_i      (lsu_load_data)
`ifdef RCA_LSQ_STATS_EN
    ,
    .lsq_loads            (lsq_loads),
    .lsq_stores           (lsq_stores),
    .lsq_full_cycles      (lsq_full_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  fn3;
    logic        ld;
  } iss_t;

  typedef struct {
    int          row;
    logic [31:0] data;
  } ret_t;

  iss_t iss_q[$];
  ret_t ret_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    grid_addr        = '0;
    grid_data        = '0;
    grid_fn3         = '0;
    grid_load        = '0;
    grid_store       = '0;
    grid_new_request = '0;
  endtask

  task automatic set_req(input int row, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] fn3, input logic ld, input logic st,
                         input bit expect_issue);
    iss_t e;
    grid_addr[row]        = addr;
    grid_data[row]        = data;
    grid_fn3[row]         = fn3;
    grid_load[row]        = ld;
    grid_store[row]       = st;
    grid_new_request[row] = 1'b1;
    if (expect_issue) begin
      e.addr = addr;
      e.data = data;
      e.fn3  = fn3;
      e.ld   = ld;
      iss_q.push_back(e);
    end
  endtask

  task automatic lsu_return(input int row, input logic [31:0] data);
    ret_t r;
    lsu_load_complete = 1'b1;
    lsu_load_data     = data;
    r.row  = row;
    r.data = data;
    ret_q.push_back(r);
  endtask

  // LSU-side and grid-side scoreboard monitors.
  always @(negedge clk) begin
    if (lsu_new_request === 1'b1) begin
      if (iss_q.size() == 0) begin
        check("iss_unexpected", 32'd1, 32'd0);
      end else begin
        iss_t e;
        e = iss_q.pop_front();
        check("iss_addr", lsu_rs1, e.addr);
        check("iss_data", lsu_rs2, e.data);
        check("iss_fn3", 32'(lsu_fn3), 32'(e.fn3));
        check("iss_load", 32'(lsu_load), 32'(e.ld));
        check("iss_store", 32'(lsu_store), 32'(!e.ld));
      end
    end
    if (|grid_load_complete) begin
      if (ret_q.size() == 0) begin
        check("ret_unexpected", 32'(grid_load_complete), 32'd0);
      end else begin
        ret_t r;
        r = ret_q.pop_front();
        check("ret_row", 32'(grid_load_complete), 32'd1 << r.row);
        check("ret_data", grid_load_data, r.data);
      end
    end
  end

  initial begin
    rst               = 1'b1;
    lsu_ready         = 1'b1;
    lsu_load_complete = 1'b0;
    lsu_load_data     = '0;
    clear_reqs();

    // Reset values.
    repeat (3) tick();
    @(negedge clk);
    check("rst_full", 32'(grid_fifo_full), 32'd0);
    check("rst_lc", 32'(grid_load_complete), 32'd0);
    check("rst_ldata", grid_load_data, 32'd0);
    check("rst_nreq", 32'(lsu_new_request), 32'd0);
    check("rst_lock", 32'(lsu_lock), 32'd0);
    check("rst_ldst", {30'd0, lsu_load, lsu_store}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("idle_nreq", 32'(lsu_new_request), 32'd0);
    check("idle_lock", 32'(lsu_lock), 32'd0);
    tick();

    // Single load from row 2.
    set_req(2, 32'h100, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("no_bypass", 32'(lsu_new_request), 32'd0);
    tick();
    clear_reqs();
    @(negedge clk);
    check("ld_issue", 32'(lsu_new_request), 32'd1);
    tick();
    tick();
    lsu_return(2, 32'hDEADBEEF);
    @(negedge clk);
    check("lc_early", 32'(grid_load_complete), 32'd0);
    tick();
    lsu_load_complete = 1'b0;
    @(negedge clk);
    check("lc_row2", 32'(grid_load_complete), 32'h4);
    tick();
    @(negedge clk);
    check("lc_one_cycle", 32'(grid_load_complete), 32'd0);
    tick();

    // Same-cycle stores from rows 0 and 3; row 1 carries an invalid load+store request.
    set_req(0, 32'h200, 32'h11, 3'd2, 1'b0, 1'b1, 1'b1);
    set_req(1, 32'h250, 32'h22, 3'd2, 1'b1, 1'b1, 1'b0);
    set_req(3, 32'h300, 32'h33, 3'd2, 1'b0, 1'b1, 1'b1);
    tick();
    clear_reqs();
    tick();
    @(negedge clk);
    check("st_lock_mid", 32'(lsu_lock), 32'd1);
    tick();
    @(negedge clk);
    check("st_lock_drop", 32'(lsu_lock), 32'd0);
    check("st_no_third", 32'(lsu_new_request), 32'd0);
    tick();

    // Fill with LSU stalled; later bursts are dropped while full, then drain in order.
    lsu_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < Rows; r++)
        set_req(r, 32'(32'h1000 + b * 16 + r * 4), 32'(b * 16 + r), 3'(r), 1'b0, 1'b1, b < 2);
      @(negedge clk);
      check("burst_full", 32'(grid_fifo_full), 32'(b >= 2));
      tick();
    end
    clear_reqs();
    @(negedge clk);
    check("full_hold", 32'(grid_fifo_full), 32'd1);
    check("full_nreq", 32'(lsu_new_request), 32'd0);
    lsu_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("drain_full", 32'(grid_fifo_full), 32'd0);
    check("drain_lock", 32'(lsu_lock), 32'd0);
    tick();

    // Load from row 1 holds the following store until its return is captured.
    set_req(1, 32'h400, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1);
    tick();
    clear_reqs();
    set_req(0, 32'h500, 32'h55, 3'd2, 1'b0, 1'b1, 1'b1);
    tick();
    clear_reqs();
    @(negedge clk);
    check("hold_a", 32'(lsu_new_request), 32'd0);
    tick();
    lsu_return(1, 32'hCAFEF00D);
    @(negedge clk);
    check("hold_b", 32'(lsu_new_request), 32'd0);
    tick();
    lsu_load_complete = 1'b0;
    @(negedge clk);
    check("lc_row1", 32'(grid_load_complete), 32'h2);
    check("st_after_ld", 32'(lsu_new_request), 32'd1);
    tick();
    tick();

    // Reset while 5 entries are queued behind a pending load.
    set_req(3, 32'h600, 32'h0, 3'd3, 1'b1, 1'b0, 1'b1);
    tick();
    clear_reqs();
    for (int r = 0; r < Rows; r++)
      set_req(r, 32'(32'h700 + r * 4), 32'(r), 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    clear_reqs();
    set_req(0, 32'h800, 32'h9, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    clear_reqs();
    @(negedge clk);
    check("pre_rst_lock", 32'(lsu_lock), 32'd1);
    check("pre_rst_nreq", 32'(lsu_new_request), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst               = 1'b0;
    lsu_load_complete = 1'b1;
    lsu_load_data     = 32'h1234;
    @(negedge clk);
    check("post_rst_lock", 32'(lsu_lock), 32'd0);
    check("post_rst_nreq", 32'(lsu_new_request), 32'd0);
    check("post_rst_full", 32'(grid_fifo_full), 32'd0);
    tick();
    lsu_load_complete = 1'b0;
    @(negedge clk);
    check("late_lc", 32'(grid_load_complete), 32'd0);
    tick();
    @(negedge clk);
    check("late_lc2", 32'(grid_load_complete), 32'd0);
    check("post_rst_idle", 32'(lsu_new_request), 32'd0);
    tick();

    // Three loads and five stores.
    for (int i = 0; i < 3; i++) begin
      set_req(i, 32'(32'h900 + i * 4), 32'h0, 3'd2, 1'b1, 1'b0, 1'b1);
      tick();
      clear_reqs();
      tick();
      lsu_return(i, 32'(32'hA0 + i));
      tick();
      lsu_load_complete = 1'b0;
      tick();
      tick();
    end
    for (int r = 0; r < Rows; r++)
      set_req(r, 32'(32'hB00 + r * 4), 32'(32'hB0 + r), 3'd2, 1'b0, 1'b1, 1'b1);
    tick();
    clear_reqs();
    set_req(0, 32'hC00, 32'hC0, 3'd2, 1'b0, 1'b1, 1'b1);
    tick();
    clear_reqs();
    repeat (6) tick();
    @(negedge clk);
    check("final_lock", 32'(lsu_lock), 32'd0);
`ifdef RCA_LSQ_STATS_EN
    check("stat_loads", lsq_loads, 32'd3);
    check("stat_stores", lsq_stores, 32'd5);
    check("stat_full", lsq_full_cycles, 32'd0);
`endif
    check("iss_left", 32'(iss_q.size()), 32'd0);
    check("ret_left", 32'(ret_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
